wb_mem_responder: RTL

- Wishbone classic-cycle slave (responder) that serves word-addressed requests from a Wishbone initiator, such as the UART Wishbone bridge or the core-side memory mux.
- Provides a byte-lane-writable SRAM, a programmable number of wait states, transfer abort on strobe/cycle drop, and an error response for out-of-range addresses.
- Intended as the drop-in responder behind the instruction/data memory muxes in the osiris_i top level.

---
 rtl/osiris_wb_pkg.sv | 21 ++
 rtl/wb_sram_array.sv | 59 +++++
 rtl/wb_mem_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/osiris_wb_pkg.sv
// Shared constants for the osiris Wishbone memory responder.
package osiris_wb_pkg;

    // Responder FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Default bus geometry
    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned SEL_WIDTH     = WB_DATA_WIDTH / 8;

    // Wait-state counter width (supports 0..15 wait states)
    localparam int unsigned CNT_WIDTH = 4;

    // Index width needed to address a RAM of the given depth
    function automatic int unsigned addr_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wb_sram_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered,
// clearable read port. Memory contents have no reset.
module wb_sram_array
    import osiris_wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned AW         = addr_bits(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    we_i,
    input  logic                    re_i,
    input  logic                    clr_i,
    input  logic [AW-1:0]           adr_i,
    input  logic [DATA_WIDTH-1:0]   wdat_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    output logic [DATA_WIDTH-1:0]   rdat_o
);

    localparam int unsigned SW = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdat_q;
    logic [DATA_WIDTH-1:0] rdat_d;

    // Byte-lane write into the array
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned b = 0; b < SW; b++) begin
                if (sel_i[b]) begin
                    mem_q[adr_i][b*8 +: 8] <= wdat_i[b*8 +: 8];
                end
            end
        end
    end

    // Next read-register value: clear wins over a read, otherwise hold
    always_comb begin
        rdat_d = rdat_q;
        if (clr_i) begin
            rdat_d = '0;
        end else if (re_i) begin
            rdat_d = mem_q[adr_i];
        end
    end

    // Read data register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdat_q <= '0;
        end else begin
            rdat_q <= rdat_d;
        end
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone classic-cycle memory responder: byte-lane-writable SRAM with
// programmable wait states, abort on cyc/stb drop and error on out-of-range.
module wb_mem_responder
    import osiris_wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o
);

    localparam int unsigned SW     = DATA_WIDTH / 8;
    localparam int unsigned RAM_AW = addr_bits(DEPTH);

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [SW-1:0]         sel_q;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  latch;
    logic                  req;
    logic                  resp;
    logic                  in_range;
    logic                  ram_we, ram_re, ram_clr;

    assign req      = wb_cyc_i & wb_stb_i;
    assign resp     = (state_q == ST_RESP);
    assign in_range = ({1'b0, adr_q} < (ADDR_WIDTH+1)'(DEPTH));

    // FSM next state, wait counter and request capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    latch = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_WIDTH'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Response and RAM strobes: everything commits on the edge leaving RESP
    always_comb begin
        ack_d   = resp & in_range;
        err_d   = resp & ~in_range;
        ram_we  = resp & we_q & in_range;
        ram_re  = resp & ~we_q & in_range;
        ram_clr = resp & ~in_range;
    end

    // FSM, counter and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Latched request fields, held through WAIT/RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adr_q <= '0;
            we_q  <= 1'b0;
            dat_q <= '0;
            sel_q <= '0;
        end else if (latch) begin
            adr_q <= wb_adr_i;
            we_q  <= wb_we_i;
            dat_q <= wb_dat_i;
            sel_q <= wb_sel_i;
        end
    end

    wb_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (RAM_AW)
    ) u_sram (
        .clk_i  (clk),
        .rst_ni (rst),
        .we_i   (ram_we),
        .re_i   (ram_re),
        .clr_i  (ram_clr),
        .adr_i  (adr_q[RAM_AW-1:0]),
        .wdat_i (dat_q),
        .sel_i  (sel_q),
        .rdat_o (wb_dat_o)
    );

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;

endmodule
